// File: rtl/ef_apb_arb_pkg.sv
// Shared types and constants for the round-robin APB master arbiter.
package ef_apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ef_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module ef_rr_arbiter
  import ef_apb_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic          hit_hi;
  logic          hit_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  // Descending scan so the lowest index in each half is the one left standing.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i >= int'(ptr)) begin
          hit_hi = 1'b1;
          idx_hi = IW'(i);
        end else begin
          hit_lo = 1'b1;
          idx_lo = IW'(i);
        end
      end
    end
    gnt_idx = hit_hi ? idx_hi : idx_lo;
    gnt     = (hit_hi || hit_lo) ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/ef_apb_master_arb.sv
// Round-robin arbiter + APB3 master sequencer shared by NUM_REQ requesters.
// Optional PREADY wait timeout enabled by defining EF_APB_ARB_TIMEOUT_EN.
module ef_apb_master_arb
  import ef_apb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic [AW-1:0]         PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DW-1:0]         PWDATA,
  input  logic [DW-1:0]         PRDATA,
  input  logic                  PREADY
);

  localparam int IW = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_bad_cfg
    $error("ef_apb_master_arb: NUM_REQ must be 2..8 and TO_CYCLES 1..65535");
  end

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gnt_q;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IW-1:0]        gnt_idx;

  ef_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = (state == IDLE) ? gnt_oh : '0;

`ifdef EF_APB_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifdef EF_APB_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            PADDR  <= req_addr[int'(gnt_idx)*AW +: AW];
            PWDATA <= req_wdata[int'(gnt_idx)*DW +: DW];
            PWRITE <= req_write[gnt_idx];
            gnt_q  <= gnt_idx;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef EF_APB_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << gnt_q;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            ptr       <= (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            state     <= IDLE;
`ifdef EF_APB_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (wait_cnt == 16'(TO_CYCLES - 1)) begin
            // Target never answered: abandon and report the canned error word.
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << gnt_q;
            rsp_rdata <= DW'(TIMEOUT_DATA);
            rsp_err   <= 1'b1;
            ptr       <= (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt  <= wait_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ef_apb_master_arb.sv
// Self-checking bench for ef_apb_master_arb against a transaction-level model.
module tb_ef_apb_master_arb;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic            rsp_err, PWRITE, PSEL, PENABLE, PREADY;
  logic [AW-1:0]   PADDR;

  always #5 PCLK = ~PCLK;

  ef_apb_master_arb #(.NUM_REQ(N), .AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int total = 0;
  int bad   = 0;

  // Model state: what the outputs must look like after the coming clock edge.
  bit            busy;
  int            phase, waits, cur_g, m_ptr;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic          cur_write;
  logic [N-1:0]  exp_rsp;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  int            grants_q[$];

  logic [N-1:0]    nx_valid, nx_write;
  logic [N*AW-1:0] nx_addr;
  logic [N*DW-1:0] nx_wdata;
  logic            nx_pready;
  logic [DW-1:0]   nx_prdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; phase = 0; waits = 0; cur_g = 0; m_ptr = 0;
    exp_rsp = '0; exp_rdata = '0; exp_err = 1'b0;
  endtask

  task automatic complete(input logic err, input logic [DW-1:0] data);
    busy      = 0;
    exp_rsp   = N'(1) << cur_g;
    exp_rdata = data;
    exp_err   = err;
    m_ptr     = (cur_g + 1) % N;
  endtask

  task automatic rand_fields();
    nx_write = N'($urandom);
    for (int i = 0; i < N; i++) begin
      nx_addr[i*AW +: AW]  = $urandom;
      nx_wdata[i*DW +: DW] = $urandom;
    end
    nx_prdata = $urandom;
  endtask

  // One clock: check outputs, drive staged inputs, check the grant, advance the model.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    int w;
    @(negedge PCLK);
    chk("psel", 64'(PSEL), 64'(busy && phase >= 1));
    chk("penable", 64'(PENABLE), 64'(busy && phase >= 2));
    if (busy) begin
      chk("paddr", 64'(PADDR), 64'(cur_addr));
      chk("pwrite", 64'(PWRITE), 64'(cur_write));
      chk("pwdata", 64'(PWDATA), 64'(cur_wdata));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    req_valid = nx_valid; req_write = nx_write; req_addr = nx_addr; req_wdata = nx_wdata;
    PREADY = nx_pready; PRDATA = nx_prdata;
    #1;
    exp_ready = '0;
    w = -1;
    if (!busy && PRESETn)
      for (int k = 0; k < N; k++)
        if (w < 0 && nx_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    exp_rsp = '0;
    if (PRESETn) begin
      if (!busy) begin
        if (w >= 0) begin
          busy = 1; phase = 1; cur_g = w;
          cur_addr  = nx_addr[w*AW +: AW];
          cur_wdata = nx_wdata[w*DW +: DW];
          cur_write = nx_write[w];
          grants_q.push_back(w);
        end
      end else if (phase == 1) begin
        phase = 2; waits = 0;
      end else if (nx_pready) begin
        complete(1'b0, cur_write ? '0 : nx_prdata);
      end else begin
        waits++;
        phase++;
`ifdef EF_APB_ARB_TIMEOUT_EN
        if (waits == TO) complete(1'b1, 32'hDEAD_BEEF);
`endif
      end
    end
  endtask

  initial begin
    int n;
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    nx_valid = '0; nx_write = '0; nx_addr = '0; nx_wdata = '0; nx_pready = 1'b0; nx_prdata = '0;
    model_reset();
    #12;
    chk("rst_psel", 64'(PSEL), 0);
    chk("rst_penable", 64'(PENABLE), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_paddr", 64'(PADDR), 0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Single zero-wait write from requester 0.
    rand_fields();
    nx_valid = 3'b001; nx_write[0] = 1'b1;
    nx_addr[0 +: AW] = 32'h10; nx_wdata[0 +: DW] = 32'hA5A5_0001; nx_pready = 1'b1;
    cycle();
    rand_fields(); nx_valid = '0;
    cycle();
    chk("wr_setup_psel", 64'(PSEL), 1);
    chk("wr_setup_penable", 64'(PENABLE), 0);
    chk("wr_paddr", 64'(PADDR), 64'h10);
    chk("wr_pwdata", 64'(PWDATA), 64'hA5A5_0001);
    cycle();
    chk("wr_access_penable", 64'(PENABLE), 1);
    cycle();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'b001);
    chk("wr_rsp_err", 64'(rsp_err), 0);

    // Read from requester 1 with three wait states.
    rand_fields();
    nx_valid = 3'b010; nx_write[1] = 1'b0; nx_addr[AW +: AW] = 32'h04;
    cycle();
    nx_valid = '0; nx_pready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      cycle();
    end
    rand_fields(); nx_pready = 1'b1; nx_prdata = 32'h1234_5678;
    cycle();
    chk("rd_held_paddr", 64'(PADDR), 64'h04);
    cycle();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'b010);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);

    // Fairness: requesters 0 and 1 held valid for six transfers.
    grants_q.delete();
    n = 0;
    while (grants_q.size() < 6 && n < 60) begin
      rand_fields(); nx_valid = 3'b011; nx_pready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    chk("fair_count", 64'(grants_q.size()), 6);
    for (int i = 0; i < grants_q.size(); i++) chk("fair_order", 64'(grants_q[i]), 64'(i % 2));
    nx_valid = '0; nx_pready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Withdrawn request: requester 1 pulses valid only while requester 0 is busy.
    grants_q.delete();
    rand_fields(); nx_valid = 3'b001; nx_pready = 1'b0;
    cycle();
    rand_fields(); nx_valid = 3'b010; nx_addr[AW +: AW] = 32'h0000_BAD0;
    cycle();
    nx_valid = '0; nx_pready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      cycle();
    end
    chk("withdraw_grants", 64'(grants_q.size()), 1);
    chk("withdraw_idle", 64'(PSEL), 0);

    // Asynchronous reset in the middle of ACCESS.
    rand_fields(); nx_valid = 3'b010; nx_pready = 1'b0;
    cycle();
    nx_valid = '0;
    cycle();
    cycle();
    chk("pre_rst_penable", 64'(PENABLE), 1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_psel", 64'(PSEL), 0);
    chk("arst_penable", 64'(PENABLE), 0);
    model_reset();
    cycle();
    cycle();
    PRESETn = 1'b1;
    rand_fields(); nx_valid = 3'b011; nx_pready = 1'b1;
    cycle();
    chk("post_rst_grant", 64'(req_ready), 64'b001);
    nx_valid = '0;
    for (int i = 0; i < 4; i++) cycle();

`ifdef EF_APB_ARB_TIMEOUT_EN
    rand_fields(); nx_valid = 3'b001; nx_write[0] = 1'b0; nx_pready = 1'b0;
    cycle();
    nx_valid = '0;
    n = 0;
    while (n < 20) begin
      cycle();
      if (rsp_valid != '0) break;
      n++;
    end
    chk("to_latency", 64'(n), 9);
    chk("to_rsp_err", 64'(rsp_err), 1);
    chk("to_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    rand_fields(); nx_valid = 3'b010; nx_pready = 1'b1;
    cycle();
    nx_valid = '0;
    for (int i = 0; i < 4; i++) cycle();
    chk("to_next_err", 64'(rsp_err), 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      nx_valid  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      nx_pready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ef_apb_master_arb.md
Name: ef_apb_master_arb

Overview:
Round-robin arbiter and APB master sequencer. It shares one APB3 target (an EF IP APB wrapper) between NUM_REQ requesters, such as testbench agents or a bus-bridge plus debug port. Each requester issues single read/write commands over a valid/ready interface. The block serialises them into legal APB SETUP/ACCESS phases and returns read data and completion to the originating requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- AW, 32, APB address width.
- DW, 32, APB data width.
- TO_CYCLES, 255, PREADY wait limit in ACCESS; used only with the optional feature.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_write  in  NUM_REQ  1=write.
- req_addr  in  NUM_REQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  packed write data.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DW  read data, shared by all requesters, qualified by rsp_valid.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- PADDR  out  AW  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Clocking and reset: one clock, PCLK. Reset PRESETn is asynchronous and active-low.
- Reset values: all outputs 0. FSM=IDLE; round-robin pointer=0, so requester 0 has highest priority first.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is high, grant the first asserted requester at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[g] is a combinational pulse for that one cycle.
  - Latch addr, write flag, wdata and g into PADDR/PWRITE/PWDATA registers; next state SETUP.
  - If no req_valid is high, stay in IDLE; req_ready=0.
- SETUP: PSEL=1, PENABLE=0. Next state ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - On PREADY=1: capture PRDATA into rsp_rdata (writes capture 0) and pulse rsp_valid[g] with rsp_err=0 on the next cycle. Next state IDLE; pointer = g+1 mod NUM_REQ.
  - On PREADY=0: hold, with all APB outputs stable.
- Leaving ACCESS: PSEL, PENABLE deasserted. PADDR/PWDATA hold their last value until the next grant.
- Latency:
  - Grant cycle T gives SETUP at T+1 and ACCESS at T+2.
  - With zero wait states, rsp_valid is at T+3 and the next grant is possible at T+3.
  - Throughput is 1 transfer per 3 cycles minimum.
- rsp_valid is a single-cycle pulse; rsp_rdata and rsp_err hold until the next completion.
- req_valid may drop without acceptance; nothing is issued for it.
- The request must remain stable only in the acceptance cycle; the data is latched on accept.
- A requester re-asserting immediately after completion waits behind other pending requesters (fairness).
- The same requester may be granted back-to-back only if no other requester is valid.
- Reset mid-ACCESS: the APB transfer is abandoned, PSEL/PENABLE drop asynchronously, and no rsp_valid is issued.
- Requester count outside 2..8: behaviour is undefined; the block raises a synthesis-time error.

Optional Feature:
- Macro: EF_APB_ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit wait counter clears on entering ACCESS and increments each cycle PREADY=0.
  - When it reaches TO_CYCLES, the block leaves ACCESS and pulses rsp_valid[g] with rsp_err=1 and rsp_rdata=32'hDEAD_BEEF.
  - The pointer advances normally.
- When undefined: no counter; ACCESS waits indefinitely for PREADY; rsp_err is tied 0.

Decomposition:
- Shared package ef_apb_arb_pkg holds:
  - the FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2);
  - the TIMEOUT_DATA constant 32'hDEAD_BEEF;
  - a clog2 helper for the grant index width.
- One sub-module, ef_rr_arbiter:
  - combinational, parameterised by NUM_REQ;
  - inputs: request vector, pointer;
  - outputs: one-hot grant and grant index.
- The FSM and APB registers stay in the top.

Test Plan:
- Single write: req0 write addr 0x10 data 0xA5A5_0001, PREADY tied 1 -> PSEL at T+1, PENABLE at T+2, PADDR=0x10, PWDATA=0xA5A5_0001, rsp_valid[0] at T+3, rsp_err=0.
- Read with 3 wait states: req1 read addr 0x04, PREADY low for 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> ACCESS held for 4 cycles with stable signals; rsp_valid[1] with rsp_rdata=0x1234_5678.
- Fairness: both requesters hold req_valid continuously for 6 transfers -> grants alternate 0,1,0,1,0,1; each rsp_valid matches its grant.
- Idle gap and reset: async PRESETn low during ACCESS -> PSEL=PENABLE=0 immediately; no rsp_valid. After release, the first grant goes to requester 0.
- Withdrawn request: req1 valid for 1 cycle while req0 is in flight, then dropped -> no APB transfer to req1's address.
- Timeout (EF_APB_ARB_TIMEOUT_EN, TO_CYCLES=8): PREADY stuck 0 -> exit ACCESS after 8 wait cycles; rsp_err=1, rsp_rdata=0xDEAD_BEEF. The next request is serviced normally.
